// File: rtl/axi_simple_bridge_if.sv
// Signal bundle between the core's simple request bus, the bridge and the AXI4 fabric.
// The master modport is the bridge's view; the slave modport is the core plus AXI slave side.
interface axi_simple_bridge_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    // core request/response bus
    logic                  if_valid;
    logic                  if_ready;
    logic                  if_read_enable;
    logic                  if_write_enable;
    logic [ADDR_W-1:0]     if_addr;
    logic [1:0]            if_size;
    logic [DATA_W-1:0]     if_data_write;
    logic [DATA_W/8-1:0]   if_data_write_mask;
    logic [DATA_W-1:0]     if_data_read;
    logic [1:0]            if_resp;

    // AXI4 write address / data / response
    logic                  axi_aw_valid;
    logic                  axi_aw_ready;
    logic [ADDR_W-1:0]     axi_aw_addr;
    logic [3:0]            axi_aw_id;
    logic [7:0]            axi_aw_len;
    logic [2:0]            axi_aw_size;
    logic [1:0]            axi_aw_burst;
    logic                  axi_w_valid;
    logic                  axi_w_ready;
    logic [DATA_W-1:0]     axi_w_data;
    logic [DATA_W/8-1:0]   axi_w_strb;
    logic                  axi_w_last;
    logic                  axi_b_valid;
    logic                  axi_b_ready;
    logic [1:0]            axi_b_resp;
    logic [3:0]            axi_b_id;

    // AXI4 read address / data
    logic                  axi_ar_valid;
    logic                  axi_ar_ready;
    logic [ADDR_W-1:0]     axi_ar_addr;
    logic [3:0]            axi_ar_id;
    logic [7:0]            axi_ar_len;
    logic [2:0]            axi_ar_size;
    logic [1:0]            axi_ar_burst;
    logic                  axi_r_valid;
    logic                  axi_r_ready;
    logic [DATA_W-1:0]     axi_r_data;
    logic [1:0]            axi_r_resp;
    logic                  axi_r_last;
    logic [3:0]            axi_r_id;

    // The bridge ignores b_id, r_last and r_id, so they are absent from its view.
    modport master (
        input  if_valid, if_read_enable, if_write_enable, if_addr, if_size,
               if_data_write, if_data_write_mask,
        output if_ready, if_data_read, if_resp,
        output axi_aw_valid, axi_aw_addr, axi_aw_id, axi_aw_len, axi_aw_size, axi_aw_burst,
        input  axi_aw_ready,
        output axi_w_valid, axi_w_data, axi_w_strb, axi_w_last,
        input  axi_w_ready,
        input  axi_b_valid, axi_b_resp,
        output axi_b_ready,
        output axi_ar_valid, axi_ar_addr, axi_ar_id, axi_ar_len, axi_ar_size, axi_ar_burst,
        input  axi_ar_ready,
        input  axi_r_valid, axi_r_data, axi_r_resp,
        output axi_r_ready
    );

    modport slave (
        output if_valid, if_read_enable, if_write_enable, if_addr, if_size,
               if_data_write, if_data_write_mask,
        input  if_ready, if_data_read, if_resp,
        input  axi_aw_valid, axi_aw_addr, axi_aw_id, axi_aw_len, axi_aw_size, axi_aw_burst,
        output axi_aw_ready,
        input  axi_w_valid, axi_w_data, axi_w_strb, axi_w_last,
        output axi_w_ready,
        output axi_b_valid, axi_b_resp, axi_b_id,
        input  axi_b_ready,
        input  axi_ar_valid, axi_ar_addr, axi_ar_id, axi_ar_len, axi_ar_size, axi_ar_burst,
        output axi_ar_ready,
        output axi_r_valid, axi_r_data, axi_r_resp, axi_r_last, axi_r_id,
        input  axi_r_ready
    );
endinterface

// File: rtl/axi_simple_bridge.sv
// Converts one core request at a time into a single-beat AXI4 read or write and returns
// the captured data/response with a one-cycle if_ready pulse. All outputs are registered.
module axi_simple_bridge #(
    parameter int         ADDR_W = 64,
    parameter int         DATA_W = 64,
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_simple_bridge_if.master  bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RADDR = 3'd1;
    localparam logic [2:0] RDATA = 3'd2;
    localparam logic [2:0] WREQ  = 3'd3;
    localparam logic [2:0] WRESP = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]          stateR;
    logic [ADDR_W-1:0]   addrR;
    logic [DATA_W-1:0]   dataR;
    logic [DATA_W/8-1:0] strbR;
    logic [1:0]          sizeR;
    logic                awDoneR;
    logic                wDoneR;
    logic                arValidR;
    logic                rReadyR;
    logic                awValidR;
    logic                wValidR;
    logic                bReadyR;
    logic                ifReadyR;
    logic [DATA_W-1:0]   ifDataReadR;
    logic [1:0]          ifRespR;

    logic arHsS;
    logic awHsS;
    logic wHsS;
    logic awAllS;
    logic wAllS;

    assign arHsS  = arValidR & bus.axi_ar_ready;
    assign awHsS  = awValidR & bus.axi_aw_ready;
    assign wHsS   = wValidR  & bus.axi_w_ready;
    // a channel counts as finished if it completed earlier or is completing this cycle
    assign awAllS = awDoneR | awHsS;
    assign wAllS  = wDoneR  | wHsS;

    // Transaction FSM together with every registered output and latched request field.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateR      <= IDLE;
            addrR       <= '0;
            dataR       <= '0;
            strbR       <= '0;
            sizeR       <= 2'b00;
            awDoneR     <= 1'b0;
            wDoneR      <= 1'b0;
            arValidR    <= 1'b0;
            rReadyR     <= 1'b0;
            awValidR    <= 1'b0;
            wValidR     <= 1'b0;
            bReadyR     <= 1'b0;
            ifReadyR    <= 1'b0;
            ifDataReadR <= '0;
            ifRespR     <= 2'b00;
        end else begin
            case (stateR)
                IDLE: begin
                    // write has priority when the core raises both enables
                    if (bus.if_valid && bus.if_write_enable) begin
                        addrR    <= bus.if_addr;
                        dataR    <= bus.if_data_write;
                        strbR    <= bus.if_data_write_mask;
                        sizeR    <= bus.if_size;
                        awValidR <= 1'b1;
                        wValidR  <= 1'b1;
                        stateR   <= WREQ;
                    end else if (bus.if_valid && bus.if_read_enable) begin
                        addrR    <= bus.if_addr;
                        sizeR    <= bus.if_size;
                        arValidR <= 1'b1;
                        stateR   <= RADDR;
                    end else begin
                        stateR   <= IDLE;
                    end
                end
                RADDR: begin
                    if (arHsS) begin
                        arValidR <= 1'b0;
                        rReadyR  <= 1'b1;
                        stateR   <= RDATA;
                    end else begin
                        stateR   <= RADDR;
                    end
                end
                RDATA: begin
                    if (bus.axi_r_valid) begin
                        ifDataReadR <= bus.axi_r_data;
                        ifRespR     <= bus.axi_r_resp;
                        rReadyR     <= 1'b0;
                        ifReadyR    <= 1'b1;
                        stateR      <= DONE;
                    end else begin
                        stateR      <= RDATA;
                    end
                end
                WREQ: begin
                    if (awHsS) begin
                        awDoneR  <= 1'b1;
                        awValidR <= 1'b0;
                    end else begin
                        awDoneR  <= awDoneR;
                    end
                    if (wHsS) begin
                        wDoneR  <= 1'b1;
                        wValidR <= 1'b0;
                    end else begin
                        wDoneR  <= wDoneR;
                    end
                    if (awAllS && wAllS) begin
                        bReadyR <= 1'b1;
                        stateR  <= WRESP;
                    end else begin
                        stateR  <= WREQ;
                    end
                end
                WRESP: begin
                    // read data register is left untouched by a write completion
                    if (bus.axi_b_valid) begin
                        ifRespR  <= bus.axi_b_resp;
                        bReadyR  <= 1'b0;
                        awDoneR  <= 1'b0;
                        wDoneR   <= 1'b0;
                        ifReadyR <= 1'b1;
                        stateR   <= DONE;
                    end else begin
                        stateR   <= WRESP;
                    end
                end
                DONE: begin
                    ifReadyR <= 1'b0;
                    stateR   <= IDLE;
                end
                default: begin
                    arValidR <= 1'b0;
                    rReadyR  <= 1'b0;
                    awValidR <= 1'b0;
                    wValidR  <= 1'b0;
                    bReadyR  <= 1'b0;
                    awDoneR  <= 1'b0;
                    wDoneR   <= 1'b0;
                    ifReadyR <= 1'b0;
                    stateR   <= IDLE;
                end
            endcase
        end
    end

    assign bus.if_ready     = ifReadyR;
    assign bus.if_data_read = ifDataReadR;
    assign bus.if_resp      = ifRespR;

    assign bus.axi_aw_valid = awValidR;
    assign bus.axi_aw_addr  = addrR;
    assign bus.axi_aw_id    = AXI_ID;
    assign bus.axi_aw_len   = 8'd0;
    assign bus.axi_aw_size  = {1'b0, sizeR};
    assign bus.axi_aw_burst = 2'b01;

    assign bus.axi_w_valid  = wValidR;
    assign bus.axi_w_data   = dataR;
    assign bus.axi_w_strb   = strbR;
    assign bus.axi_w_last   = 1'b1;
    assign bus.axi_b_ready  = bReadyR;

    assign bus.axi_ar_valid = arValidR;
    assign bus.axi_ar_addr  = addrR;
    assign bus.axi_ar_id    = AXI_ID;
    assign bus.axi_ar_len   = 8'd0;
    assign bus.axi_ar_size  = {1'b0, sizeR};
    assign bus.axi_ar_burst = 2'b01;
    assign bus.axi_r_ready  = rReadyR;
endmodule

// File: tb/tb_axi_simple_bridge.sv
// Directed bench for axi_simple_bridge: the core side and a scripted AXI slave are driven in one
// sequence; expected completions go into a scoreboard queue and are checked on each if_ready.
module tb_axi_simple_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;

    axi_simple_bridge_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    axi_simple_bridge #(.ADDR_W(64), .DATA_W(64), .AXI_ID(4'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
    } sbEntry;

    sbEntry      sb[$];
    int          nVec = 0;
    int          nErr = 0;
    logic [63:0] lastData = 64'h0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for if_ready, check its latency, pop and compare, then check it is one cycle wide.
    task automatic waitReady(input string tag, input int budget, input int expCycles);
        int     cycles;
        sbEntry e;
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!bus.if_ready && cycles < budget);
        chk({tag, " ready"}, 64'(bus.if_ready), 64'h1);
        chk({tag, " latency"}, 64'(cycles), 64'(expCycles));
        chk({tag, " sb_nonempty"}, 64'(sb.size() > 0), 64'h1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " data"}, bus.if_data_read, e.data);
            chk({tag, " resp"}, 64'(bus.if_resp), 64'(e.resp));
        end
        tick();
        chk({tag, " pulse_end"}, 64'(bus.if_ready), 64'h0);
    endtask

    task automatic startReq(input logic wr, input logic rd, input logic [63:0] addr,
                            input logic [1:0] size, input logic [63:0] wdata, input logic [7:0] mask);
        bus.if_valid           = 1'b1;
        bus.if_write_enable    = wr;
        bus.if_read_enable     = rd;
        bus.if_addr            = addr;
        bus.if_size            = size;
        bus.if_data_write      = wdata;
        bus.if_data_write_mask = mask;
    endtask

    task automatic dropReq();
        bus.if_valid        = 1'b0;
        bus.if_write_enable = 1'b0;
        bus.if_read_enable  = 1'b0;
    endtask

    // Read against a slave that accepts AR and returns the beat without wait states.
    task automatic zeroWaitRead(input string tag, input logic [63:0] addr,
                                input logic [63:0] rdata, input logic [1:0] rresp);
        startReq(1'b0, 1'b1, addr, 2'b11, 64'h0, 8'h00);
        bus.axi_ar_ready = 1'b1;
        bus.axi_r_valid  = 1'b1;
        bus.axi_r_data   = rdata;
        bus.axi_r_resp   = rresp;
        sb.push_back('{data: rdata, resp: rresp});
        tick();
        dropReq();
        chk({tag, " ar_valid c1"}, 64'(bus.axi_ar_valid), 64'h1);
        chk({tag, " ar_addr"}, bus.axi_ar_addr, addr);
        chk({tag, " ar_size"}, 64'(bus.axi_ar_size), 64'h3);
        chk({tag, " ar_len/burst/id"},
            64'({bus.axi_ar_len, bus.axi_ar_burst, bus.axi_ar_id}), 64'({8'd0, 2'b01, 4'd0}));
        chk({tag, " no aw"}, 64'(bus.axi_aw_valid), 64'h0);
        tick();
        chk({tag, " ar_valid c2"}, 64'(bus.axi_ar_valid), 64'h0);
        chk({tag, " r_ready c2"}, 64'(bus.axi_r_ready), 64'h1);
        waitReady(tag, 8, 1);
        bus.axi_ar_ready = 1'b0;
        bus.axi_r_valid  = 1'b0;
        lastData = rdata;
    endtask

    initial begin
        dropReq();
        bus.if_addr            = 64'h0;
        bus.if_size            = 2'b00;
        bus.if_data_write      = 64'h0;
        bus.if_data_write_mask = 8'h00;
        bus.axi_aw_ready = 1'b0;
        bus.axi_w_ready  = 1'b0;
        bus.axi_b_valid  = 1'b0;
        bus.axi_b_resp   = 2'b00;
        bus.axi_b_id     = 4'd0;
        bus.axi_ar_ready = 1'b0;
        bus.axi_r_valid  = 1'b0;
        bus.axi_r_data   = 64'h0;
        bus.axi_r_resp   = 2'b00;
        bus.axi_r_last   = 1'b1;
        bus.axi_r_id     = 4'd0;

        // reset state
        tick();
        tick();
        chk("rst if_ready", 64'(bus.if_ready), 64'h0);
        chk("rst if_data_read", bus.if_data_read, 64'h0);
        chk("rst valids", 64'({bus.axi_ar_valid, bus.axi_aw_valid, bus.axi_w_valid}), 64'h0);
        chk("rst readies", 64'({bus.axi_r_ready, bus.axi_b_ready}), 64'h0);
        rst = 1'b0;
        tick();

        // zero-wait read: if_ready lands in cycle 3
        zeroWaitRead("rd0", 64'h0000_0000_8000_0008, 64'h1122_3344_5566_7788, 2'b00);

        // write with W accepted first and AW three cycles later
        startReq(1'b1, 1'b0, 64'h0000_0000_8000_0010, 2'b10, 64'h0000_0000_DEAD_BEEF, 8'h0F);
        bus.axi_w_ready = 1'b1;
        sb.push_back('{data: lastData, resp: 2'b00});
        tick();
        dropReq();
        chk("wr aw/w valid", 64'({bus.axi_aw_valid, bus.axi_w_valid}), 64'h3);
        chk("wr aw_addr", bus.axi_aw_addr, 64'h0000_0000_8000_0010);
        chk("wr w_data", bus.axi_w_data, 64'h0000_0000_DEAD_BEEF);
        chk("wr w_strb", 64'(bus.axi_w_strb), 64'h0F);
        chk("wr w_last", 64'(bus.axi_w_last), 64'h1);
        chk("wr aw_size", 64'(bus.axi_aw_size), 64'h2);
        chk("wr aw_len/burst/id",
            64'({bus.axi_aw_len, bus.axi_aw_burst, bus.axi_aw_id}), 64'({8'd0, 2'b01, 4'd0}));
        tick();
        bus.axi_w_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wr w_valid dropped", 64'(bus.axi_w_valid), 64'h0);
            chk("wr aw_valid held", 64'(bus.axi_aw_valid), 64'h1);
            chk("wr b_ready early", 64'(bus.axi_b_ready), 64'h0);
            if (i == 2) bus.axi_aw_ready = 1'b1;
            tick();
        end
        bus.axi_aw_ready = 1'b0;
        chk("wr aw_valid done", 64'(bus.axi_aw_valid), 64'h0);
        chk("wr b_ready", 64'(bus.axi_b_ready), 64'h1);
        bus.axi_b_valid = 1'b1;
        bus.axi_b_resp  = 2'b00;
        waitReady("wr0", 8, 1);
        bus.axi_b_valid = 1'b0;

        // read with AR stalled five cycles and the beat four cycles after that
        startReq(1'b0, 1'b1, 64'h0000_0000_8000_0020, 2'b11, 64'h0, 8'h00);
        sb.push_back('{data: 64'h0A0B_0C0D_0E0F_1011, resp: 2'b00});
        tick();
        dropReq();
        for (int i = 0; i < 5; i++) begin
            chk("stall ar_valid", 64'(bus.axi_ar_valid), 64'h1);
            chk("stall ar_addr", bus.axi_ar_addr, 64'h0000_0000_8000_0020);
            chk("stall no ready", 64'(bus.if_ready), 64'h0);
            tick();
        end
        bus.axi_ar_ready = 1'b1;
        tick();
        bus.axi_ar_ready = 1'b0;
        chk("stall ar_valid done", 64'(bus.axi_ar_valid), 64'h0);
        for (int i = 0; i < 4; i++) begin
            chk("stall r_ready", 64'(bus.axi_r_ready), 64'h1);
            chk("stall no ready r", 64'(bus.if_ready), 64'h0);
            chk("stall data hold", bus.if_data_read, lastData);
            tick();
        end
        bus.axi_r_valid = 1'b1;
        bus.axi_r_data  = 64'h0A0B_0C0D_0E0F_1011;
        bus.axi_r_resp  = 2'b00;
        waitReady("rd_stall", 8, 1);
        bus.axi_r_valid = 1'b0;
        lastData = 64'h0A0B_0C0D_0E0F_1011;

        // SLVERR read: response forwarded, data still captured and held afterwards
        zeroWaitRead("rd_slverr", 64'h0000_0000_8000_0018, 64'hCAFE_F00D_1234_5678, 2'b10);
        chk("slverr resp hold", 64'(bus.if_resp), 64'h2);
        chk("slverr idle", 64'({bus.axi_ar_valid, bus.axi_r_ready}), 64'h0);

        // if_valid with neither enable stays idle
        startReq(1'b0, 1'b0, 64'h0000_0000_8000_0028, 2'b11, 64'h0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("noen idle", 64'({bus.axi_ar_valid, bus.axi_aw_valid, bus.axi_w_valid}), 64'h0);
        end
        dropReq();
        tick();

        // asynchronous reset while waiting in RDATA
        startReq(1'b0, 1'b1, 64'h0000_0000_8000_0038, 2'b11, 64'h0, 8'h00);
        bus.axi_ar_ready = 1'b1;
        tick();
        dropReq();
        tick();
        bus.axi_ar_ready = 1'b0;
        chk("arst pre r_ready", 64'(bus.axi_r_ready), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst if_data_read", bus.if_data_read, 64'h0);
        chk("arst if_resp/ready", 64'({bus.if_resp, bus.if_ready}), 64'h0);
        chk("arst handshakes", 64'({bus.axi_r_ready, bus.axi_ar_valid, bus.axi_aw_valid,
                                    bus.axi_w_valid, bus.axi_b_ready}), 64'h0);
        chk("arst addr", bus.axi_ar_addr, 64'h0);
        tick();
        rst = 1'b0;
        tick();
        lastData = 64'h0;
        zeroWaitRead("rd_after_rst", 64'h0000_0000_8000_0040, 64'h0102_0304_0506_0708, 2'b00);

        // both enables: write wins, no AR ever issued; EXOKAY forwarded
        startReq(1'b1, 1'b1, 64'h0000_0000_8000_0030, 2'b11, 64'h55AA_55AA_0F0F_F0F0, 8'hFF);
        bus.axi_aw_ready = 1'b1;
        bus.axi_w_ready  = 1'b1;
        sb.push_back('{data: lastData, resp: 2'b01});
        tick();
        dropReq();
        chk("both aw/w valid", 64'({bus.axi_aw_valid, bus.axi_w_valid}), 64'h3);
        chk("both no ar", 64'(bus.axi_ar_valid), 64'h0);
        chk("both w_data", bus.axi_w_data, 64'h55AA_55AA_0F0F_F0F0);
        tick();
        bus.axi_aw_ready = 1'b0;
        bus.axi_w_ready  = 1'b0;
        chk("both b_ready", 64'(bus.axi_b_ready), 64'h1);
        chk("both no ar c2", 64'(bus.axi_ar_valid), 64'h0);
        bus.axi_b_valid = 1'b1;
        bus.axi_b_resp  = 2'b01;
        waitReady("wr_both", 8, 1);
        bus.axi_b_valid = 1'b0;
        chk("both no ar end", 64'(bus.axi_ar_valid), 64'h0);

        chk("sb drained", 64'(sb.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
